// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, runs the req/ack fetch handshake and
// drives the IF/ID pipeline register, with one-delay-slot branch redirects.
module inst_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP_INST = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        branch_flag_i,
   input  logic [15:0] branch_addr_i,
   output logic        mem_req_o,
   output logic [15:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [15:0] mem_rdata_i,
   output logic [15:0] pc_o,
   output logic [15:0] inst_o,
   output logic        valid_o
);

   localparam int unsigned W = 16;

   typedef enum logic {REQ = 1'b0, HOLD = 1'b1} state_t;

   state_t         state;
   logic [W-1:0]   pc_r;
   logic [W-1:0]   buf_inst;
   logic [W-1:0]   buf_pc;
   logic           buf_v;
   logic           pend_v;
   logic [W-1:0]   pend_addr;

   logic           fetch_done;
   logic           branch_acc;
   logic [W-1:0]   a_inc;
   logic [W-1:0]   next_pc;

   // Request drops immediately under reset so an in-flight fetch is abandoned.
   assign mem_req_o  = (state == REQ) && !rst;
   assign mem_addr_o = pc_r;

   assign fetch_done = mem_ack_i && mem_req_o;
   assign branch_acc = branch_flag_i && !stall_i;
   assign a_inc      = W'(pc_r + W'(1));

   // Redirect priority: branch on this edge, then a deferred redirect, then sequential.
   always_comb begin
      next_pc = a_inc;
      if (branch_acc)
         next_pc = branch_addr_i;
      else if (pend_v)
         next_pc = pend_addr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= REQ;
         pc_r      <= RESET_PC;
         buf_inst  <= NOP_INST;
         buf_pc    <= '0;
         buf_v     <= 1'b0;
         pend_v    <= 1'b0;
         pend_addr <= '0;
         pc_o      <= '0;
         inst_o    <= NOP_INST;
         valid_o   <= 1'b0;
      end else begin
         case (state)
            REQ: begin
               if (fetch_done) begin
                  pc_r   <= next_pc;
                  pend_v <= 1'b0;
                  if (!stall_i) begin
                     pc_o    <= a_inc;
                     inst_o  <= mem_rdata_i;
                     valid_o <= 1'b1;
                  end else begin
                     buf_pc   <= a_inc;
                     buf_inst <= mem_rdata_i;
                     buf_v    <= 1'b1;
                     state    <= HOLD;
                  end
               end else if (!stall_i) begin
                  // Bubble; a branch seen now waits for the delay slot to land.
                  inst_o  <= NOP_INST;
                  valid_o <= 1'b0;
                  if (branch_flag_i) begin
                     pend_v    <= 1'b1;
                     pend_addr <= branch_addr_i;
                  end
               end
            end
            HOLD: begin
               if (!stall_i && buf_v) begin
                  pc_o    <= buf_pc;
                  inst_o  <= buf_inst;
                  valid_o <= 1'b1;
                  buf_v   <= 1'b0;
                  state   <= REQ;
                  // Buffered word is the delay slot; pc_r already advanced past it.
                  if (branch_flag_i)
                     pc_r <= branch_addr_i;
               end
            end
            default: state <= REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a memory returning addr ^ A5A5, driven
// step by step with hand-computed expected IF/ID and request values.
module tb_inst_fetch;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        branch_flag_i;
   logic [15:0] branch_addr_i;
   logic        mem_req_o;
   logic [15:0] mem_addr_o;
   logic        mem_ack_i;
   logic [15:0] mem_rdata_i;
   logic [15:0] pc_o;
   logic [15:0] inst_o;
   logic        valid_o;

   int checks;
   int failures;

   inst_fetch #(.RESET_PC(16'h0000), .NOP_INST(16'h0800)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .branch_flag_i (branch_flag_i),
      .branch_addr_i (branch_addr_i),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_ack_i     (mem_ack_i),
      .mem_rdata_i   (mem_rdata_i),
      .pc_o          (pc_o),
      .inst_o        (inst_o),
      .valid_o       (valid_o)
   );

   assign mem_rdata_i = mem_addr_o ^ 16'hA5A5;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_ifid(input string tag, input logic [15:0] epc,
                           input logic [15:0] einst, input logic ev);
      chk({tag, ".pc"}, pc_o, epc);
      chk({tag, ".inst"}, inst_o, einst);
      chk({tag, ".valid"}, 16'(valid_o), 16'(ev));
   endtask

   task automatic chk_mem(input string tag, input logic ereq, input logic [15:0] eaddr);
      chk({tag, ".req"}, 16'(mem_req_o), 16'(ereq));
      if (ereq) chk({tag, ".addr"}, mem_addr_o, eaddr);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      stall_i = 1'b0;
      branch_flag_i = 1'b0;
      branch_addr_i = 16'h0000;
      mem_ack_i = 1'b0;

      // Reset state
      tick();
      tick();
      chk_ifid("reset", 16'h0000, 16'h0800, 1'b0);
      chk("reset.req", 16'(mem_req_o), 16'h0000);

      // Same-cycle ack memory, sequential stream
      rst = 1'b0;
      mem_ack_i = 1'b1;
      #1;
      chk_mem("first_req", 1'b1, 16'h0000);
      tick();
      chk_ifid("seq0", 16'h0001, 16'hA5A5, 1'b1);
      chk_mem("seq0", 1'b1, 16'h0001);
      tick();
      chk_ifid("seq1", 16'h0002, 16'hA5A4, 1'b1);
      tick();
      chk_ifid("seq2", 16'h0003, 16'hA5A7, 1'b1);
      tick();
      chk_ifid("seq3", 16'h0004, 16'hA5A6, 1'b1);
      chk_mem("seq3", 1'b1, 16'h0004);

      // Stall for 3 cycles while addr 4 is acked
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_ifid("stall_hold", 16'h0004, 16'hA5A6, 1'b1);
         chk_mem("stall_hold", 1'b0, 16'h0000);
      end
      stall_i = 1'b0;
      tick();
      chk_ifid("stall_release", 16'h0005, 16'hA5A1, 1'b1);
      chk_mem("stall_release", 1'b1, 16'h0005);

      // Branch accepted on the ack edge of addr 5
      branch_flag_i = 1'b1;
      branch_addr_i = 16'h0020;
      tick();
      branch_flag_i = 1'b0;
      chk_ifid("br_slot", 16'h0006, 16'hA5A0, 1'b1);
      chk_mem("br_slot", 1'b1, 16'h0020);
      tick();
      chk_ifid("br_target", 16'h0021, 16'hA585, 1'b1);

      // Move fetch to addr 7, then slow memory with a mid-request branch
      branch_flag_i = 1'b1;
      branch_addr_i = 16'h0007;
      tick();
      chk_ifid("to7", 16'h0022, 16'hA584, 1'b1);
      chk_mem("to7", 1'b1, 16'h0007);
      mem_ack_i = 1'b0;
      branch_addr_i = 16'h0040;
      tick();
      branch_flag_i = 1'b0;
      chk_ifid("slow_bubble0", 16'h0022, 16'h0800, 1'b0);
      chk_mem("slow_bubble0", 1'b1, 16'h0007);
      tick();
      chk_ifid("slow_bubble1", 16'h0022, 16'h0800, 1'b0);
      chk_mem("slow_bubble1", 1'b1, 16'h0007);
      mem_ack_i = 1'b1;
      tick();
      chk_ifid("pend_slot", 16'h0008, 16'hA5A2, 1'b1);
      chk_mem("pend_slot", 1'b1, 16'h0040);
      tick();
      chk_ifid("pend_target", 16'h0041, 16'hA5E5, 1'b1);

      // Wrap at FFFF
      branch_flag_i = 1'b1;
      branch_addr_i = 16'hFFFF;
      tick();
      branch_flag_i = 1'b0;
      chk_mem("to_ffff", 1'b1, 16'hFFFF);
      tick();
      chk_ifid("wrap", 16'h0000, 16'h5A5A, 1'b1);
      chk_mem("wrap", 1'b1, 16'h0000);

      // Reset while a request at addr 9 waits; ack arrives during reset
      branch_flag_i = 1'b1;
      branch_addr_i = 16'h0009;
      tick();
      branch_flag_i = 1'b0;
      mem_ack_i = 1'b0;
      chk_mem("to9", 1'b1, 16'h0009);
      tick();
      chk_ifid("wait9", 16'h0001, 16'h0800, 1'b0);
      rst = 1'b1;
      mem_ack_i = 1'b1;
      #1;
      chk("rst_req_low", 16'(mem_req_o), 16'h0000);
      tick();
      chk_ifid("mid_reset", 16'h0000, 16'h0800, 1'b0);
      chk("mid_reset.req", 16'(mem_req_o), 16'h0000);
      rst = 1'b0;
      mem_ack_i = 1'b0;
      #1;
      chk_mem("post_reset", 1'b1, 16'h0000);
      tick();
      chk_ifid("no_stale", 16'h0000, 16'h0800, 1'b0);
      mem_ack_i = 1'b1;
      tick();
      chk_ifid("post_reset_fetch", 16'h0001, 16'hA5A5, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined CPU. It owns the PC and issues requests to the instruction memory port over a req/ack handshake. It delivers `pc_o`/`inst_o`/`valid_o` to the decode stage and accepts `branch_flag_i`/`branch_addr_i` back from decode. Branches have one delay slot: the instruction after a branch always executes.

## Interface
- `RESET_PC`, default 16'h0000: first fetch address after reset.
- `NOP_INST`, default 16'h0800: encoding driven on `inst_o` for bubbles.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall_i`  in  1  pipeline control; 1 = hold IF/ID register, decode not advancing.
- `branch_flag_i`  in  1  decode redirect request, valid when `stall_i`=0.
- `branch_addr_i`  in  16  redirect target.
- `mem_req_o`  out  1  fetch request, level, held until ack.
- `mem_addr_o`  out  16  fetch address, stable while `mem_req_o`=1.
- `mem_ack_i`  in  1  one-cycle pulse; completes the current request.
- `mem_rdata_i`  in  16  instruction word, valid in the ack cycle.
- `pc_o`  out  16  fetch address + 1 of `inst_o`. Decode computes branch targets as `pc_o` + offset.
- `inst_o`  out  16  instruction to decode.
- `valid_o`  out  1  1 = `inst_o` is a real fetched instruction; 0 = bubble.

## Operation
- Registers:
  - `pc_r[15:0]`: next address to request.
  - `state`: REQ or HOLD.
  - `buf_inst`, `buf_pc`, `buf_v`: one-entry skid buffer.
  - `pend_v`, `pend_addr`: deferred redirect.
  - IF/ID output registers.
- `mem_req_o` = (state==REQ) && !rst.
- `mem_addr_o` = `pc_r`.
- "Fetch completes" = `mem_ack_i` && `mem_req_o`. The completed address is `a` = `pc_r`.
- Next-PC on completion, in priority order:
  - `branch_addr_i` if a branch is accepted this edge;
  - else `pend_addr` if `pend_v` (then clear `pend_v`);
  - else `a`+1, modulo 2^16 (wraps FFFF→0000).
- Branch accepted = `branch_flag_i` && !`stall_i`.
- Delay slot is the first real instruction loaded into the IF/ID register at or after the acceptance edge.
  - If the load happens on the acceptance edge (from ack or from the buffer): `pc_r` <= `branch_addr_i` directly.
  - If the acceptance edge loads a bubble: `pend_v`<=1, `pend_addr`<=`branch_addr_i`. Applied at the next completion.
  - A new accepted branch overwrites `pend_addr`.
- State REQ:
  - Completion with `stall_i`=0: IF/ID <= {`a`+1, `mem_rdata_i`, 1}; `pc_r` <= next-PC; stay REQ.
  - Completion with `stall_i`=1: buffer <= {`a`+1, `mem_rdata_i`}, `buf_v`=1; `pc_r` <= next-PC; go HOLD.
  - No completion with `stall_i`=0: IF/ID <= {`pc_o` held, `NOP_INST`, 0} (bubble).
  - No completion with `stall_i`=1: hold.
- State HOLD:
  - `mem_req_o`=0.
  - While `stall_i`=1: hold everything.
  - When `stall_i`=0: IF/ID <= buffer with valid=1; `buf_v`<=0; go REQ.
- `stall_i`=1 always freezes `pc_o`, `inst_o`, `valid_o`.
- Memory contract: the memory abandons any request when `mem_req_o` falls. An ack while `mem_req_o`=0 is ignored.

## Timing
- Reset values (rst sampled high at an edge):
  - `pc_r`=`RESET_PC`, state=REQ;
  - `buf_v`=0, `pend_v`=0;
  - `pc_o`=0, `inst_o`=`NOP_INST`, `valid_o`=0.
  - `mem_req_o`=0 during any cycle with rst=1.
- Reset mid-request aborts the request. The first request after reset is at `RESET_PC`, in the cycle after rst falls.
- Latency: request issued and acked in cycle t → `inst_o` valid from cycle t+1.
- Throughput: one instruction per cycle with a same-cycle-ack memory.
- Outstanding requests: at most one; no new request in the ack cycle's address slot until `pc_r` updates, so the address changes only after an ack.
- Buffer and branch conflicts:
  - The buffer never overflows: HOLD issues no requests.
  - Branch acceptance cannot coincide with HOLD plus stall, because acceptance requires `stall_i`=0.

## Test plan
- Reset, then a memory that acks in the same cycle with rdata = addr ^ 16'hA5A5: `mem_addr_o` runs 0,1,2…. `inst_o` runs A5A5, A5A4, A5A7 with `pc_o` 1,2,3, and `valid_o`=1 from the second cycle.
- `stall_i` raised for 3 cycles while the ack for addr 4 arrives: `mem_req_o`=0 for those cycles and IF/ID holds addr 3's word. After release, `inst_o`=word(4) with `pc_o`=5, and the next request goes to addr 5.
- Branch accepted (`branch_addr_i`=16'h0020) on the edge addr 5 is acked: `pc_o`=6 carries the delay slot, and the next `mem_addr_o`=0020.
- Memory acking every 3rd cycle, branch to 0x0040 accepted mid-request at addr 7: bubbles (`inst_o`=0800, `valid_o`=0) appear until the ack. Addr 7 is delivered as the delay slot, then the request goes to 0040.
- `pc_r`=FFFF acked: next `mem_addr_o`=0000, and `pc_o`=0000 for that word.
- rst pulsed for one cycle while a request at addr 9 awaits ack, with ack arriving during rst: the ack is ignored, outputs return to reset values, and the next request is at `RESET_PC` with no stale delivery.
